// File: rtl/snake_body_if.sv
// Bundle of the snake body's game-control, pixel-probe and status signals.
// The slave side is the snake_body block; the master side is whoever drives it.
interface snake_body_if;
    logic        move_tick;
    logic [1:0]  dir_in;
    logic        grow;
    logic [10:0] pixel_xpos;
    logic [10:0] pixel_ypos;
    logic        snack_r;
    logic        fin;
    logic [9:0]  head_x;
    logic [9:0]  head_y;
    logic [4:0]  snake_len;

    modport master (
        output move_tick, dir_in, grow, pixel_xpos, pixel_ypos,
        input  snack_r, fin, head_x, head_y, snake_len
    );

    modport slave (
        input  move_tick, dir_in, grow, pixel_xpos, pixel_ypos,
        output snack_r, fin, head_x, head_y, snake_len
    );
endinterface

// File: rtl/snake_body.sv
// Snake segment storage, stepping with wall/self collision, and per-pixel body hit.
// Segment 0 is the head; segments shift down the array by one on every legal step.
module snake_body #(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int BLOCK_W  = 10,
    parameter int H_DISP   = 800,
    parameter int V_DISP   = 600,
    parameter int INIT_X   = 400,
    parameter int INIT_Y   = 300
) (
    input  logic         vga_clk,
    input  logic         sys_rst_n,
    snake_body_if.slave  bus
);

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    localparam logic [9:0]  LP_BW10   = 10'(BLOCK_W);
    localparam logic [10:0] LP_BW11   = 11'(BLOCK_W);
    localparam logic [10:0] LP_XLIM   = 11'(H_DISP - BLOCK_W);
    localparam logic [10:0] LP_YLIM   = 11'(V_DISP - BLOCK_W);
    localparam logic [4:0]  LP_MAXLEN = 5'(MAX_LEN);
    localparam logic [4:0]  LP_INILEN = 5'(INIT_LEN);

    logic [9:0]  r_seg_x [MAX_LEN];
    logic [9:0]  r_seg_y [MAX_LEN];
    dir_t        r_dir;
    logic [4:0]  r_len;
    logic        r_grow_pend;
    logic        r_fin;
    logic        r_snack;

    dir_t        w_dir;
    dir_t        w_req;
    dir_t        w_req_opp;
    logic [10:0] w_hx;
    logic [10:0] w_hy;
    logic [9:0]  w_nx;
    logic [9:0]  w_ny;
    logic        w_wall;
    logic        w_self_hit;
    logic [4:0]  w_self_lim;
    logic        w_grows;
    logic        w_step;
    logic        w_hit;
    logic        w_pix_hit;

    assign w_req     = dir_t'(bus.dir_in);
    assign w_req_opp = dir_t'({bus.dir_in[1], ~bus.dir_in[0]});
    assign w_hx      = {1'b0, r_seg_x[0]};
    assign w_hy      = {1'b0, r_seg_y[0]};
    assign w_grows   = (r_grow_pend | bus.grow) && (r_len < LP_MAXLEN);
    assign w_step    = bus.move_tick && !r_fin;
    assign w_hit     = w_wall | w_self_hit;

    // Heading selection, candidate head and wall check (done on 11-bit sums before subtracting).
    always_comb begin
        w_dir  = r_dir;
        w_nx   = r_seg_x[0];
        w_ny   = r_seg_y[0];
        w_wall = 1'b0;
        if (w_req_opp != r_dir) begin
            w_dir = w_req;
        end
        case (w_dir)
            DIR_UP: begin
                w_wall = w_hy < LP_BW11;
                w_ny   = r_seg_y[0] - LP_BW10;
            end
            DIR_DOWN: begin
                w_wall = (w_hy + LP_BW11) > LP_YLIM;
                w_ny   = r_seg_y[0] + LP_BW10;
            end
            DIR_LEFT: begin
                w_wall = w_hx < LP_BW11;
                w_nx   = r_seg_x[0] - LP_BW10;
            end
            default: begin
                w_wall = (w_hx + LP_BW11) > LP_XLIM;
                w_nx   = r_seg_x[0] + LP_BW10;
            end
        endcase
    end

    // The tail vacates on a normal step, so it only counts as an obstacle when growing.
    always_comb begin
        w_self_hit = 1'b0;
        w_self_lim = w_grows ? (r_len - 5'd1) : (r_len - 5'd2);
        for (int j = 1; j < MAX_LEN; j++) begin
            if ((5'(j) <= w_self_lim) && (r_seg_x[j] == w_nx) && (r_seg_y[j] == w_ny)) begin
                w_self_hit = 1'b1;
            end
        end
    end

    always_comb begin
        w_pix_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((5'(i) < r_len) &&
                (bus.pixel_xpos >= {1'b0, r_seg_x[i]}) &&
                (bus.pixel_xpos <  ({1'b0, r_seg_x[i]} + LP_BW11)) &&
                (bus.pixel_ypos >= {1'b0, r_seg_y[i]}) &&
                (bus.pixel_ypos <  ({1'b0, r_seg_y[i]} + LP_BW11))) begin
                w_pix_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= 10'(INIT_X - i * BLOCK_W);
                r_seg_y[i] <= 10'(INIT_Y);
            end
        end else if (w_step && !w_hit) begin
            for (int k = 1; k < MAX_LEN; k++) begin
                r_seg_x[k] <= r_seg_x[k-1];
                r_seg_y[k] <= r_seg_y[k-1];
            end
            r_seg_x[0] <= w_nx;
            r_seg_y[0] <= w_ny;
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_dir       <= DIR_RIGHT;
            r_len       <= LP_INILEN;
            r_grow_pend <= 1'b0;
            r_fin       <= 1'b0;
            r_snack     <= 1'b0;
        end else begin
            r_snack <= w_pix_hit;
            if (w_step) begin
                r_grow_pend <= 1'b0;
                if (w_hit) begin
                    r_fin <= 1'b1;
                end else begin
                    r_dir <= w_dir;
                    if (w_grows) begin
                        r_len <= r_len + 5'd1;
                    end
                end
            end else if (bus.grow) begin
                r_grow_pend <= 1'b1;
            end
        end
    end

    assign bus.snack_r   = r_snack;
    assign bus.fin       = r_fin;
    assign bus.head_x    = r_seg_x[0];
    assign bus.head_y    = r_seg_y[0];
    assign bus.snake_len = r_len;

endmodule

// File: doc/snake_body.md
Name: snake_body

Overview:
- Holds the snake's segment positions and advances them one block per game step.
- Reports wall and self-collision as a sticky game-over flag, `fin`.
- Renders a per-pixel body hit flag, `snack_r`.
- Sits directly upstream of the pixel colouring stage: it consumes the VGA driver's `pixel_xpos`/`pixel_ypos` and feeds that stage `snack_r` and `fin`.

Parameters:
- MAX_LEN, 16: maximum number of segments (segment storage depth).
- INIT_LEN, 3: snake length after reset; must be 2..MAX_LEN.
- BLOCK_W, 10: segment edge in pixels; also the step size per move.
- H_DISP, 800: active width in pixels.
- V_DISP, 600: active height in pixels.
- INIT_X, 400: head x after reset; a multiple of BLOCK_W.
- INIT_Y, 300: head y after reset; a multiple of BLOCK_W.

Ports:
- vga_clk  input  1  pixel/system clock; all logic on the rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- move_tick  input  1  single-cycle pulse; perform one game step.
- dir_in  input  2  requested heading: 00 up, 01 down, 10 left, 11 right.
- grow  input  1  single-cycle pulse; food eaten.
- pixel_xpos  input  11  current pixel x.
- pixel_ypos  input  11  current pixel y.
- snack_r  output  1  current pixel lies on a live segment (registered).
- fin  output  1  game over; sticky.
- head_x  output  10  segment 0 x, top-left corner.
- head_y  output  10  segment 0 y, top-left corner.
- snake_len  output  5  number of live segments.

Behaviour:

Reset (sys_rst_n low, asynchronous):
- Segment i = (INIT_X - i*BLOCK_W, INIT_Y) for every i < MAX_LEN.
- Heading = right; snake_len = INIT_LEN.
- grow_pend = 0; fin = 0; snack_r = 0.
- head_x = INIT_X; head_y = INIT_Y.
- Reset mid-step aborts the step; the reset state wins.

Heading:
- dir_in is sampled only in a move_tick cycle.
- A request exactly opposite the current heading is ignored (heading kept). Any other request becomes the heading used for that same step.

Growth:
- grow sets grow_pend.
- The next move_tick consumes grow_pend. If grow and move_tick fall in the same cycle, growth applies to that step.
- At snake_len = MAX_LEN, growth is discarded (length saturates) but grow_pend still clears.

Step (move_tick = 1 and fin = 0):
- Candidate head nh = head offset by ±BLOCK_W on the heading axis.
- Wall hit, checked before any subtraction:
  - up with head_y < BLOCK_W;
  - down with head_y + BLOCK_W > V_DISP - BLOCK_W;
  - left with head_x < BLOCK_W;
  - right with head_x + BLOCK_W > H_DISP - BLOCK_W.
- Self hit: nh equals segment j for any j in 1..snake_len-2.
  - When growing, the range extends to snake_len-1, because the tail does not vacate.
- On any hit: fin <= 1; segments, length and heading unchanged.
- Otherwise:
  - Segment[k] <= segment[k-1] for k = 1..MAX_LEN-1; segment[0] <= nh.
  - snake_len increments if the step grows.
- Segment storage, snake_len, head_x and head_y all update on the clock edge after the tick (1-cycle latency).

Other cycles:
- move_tick while fin = 1 is ignored.
- fin stays 1 until reset.

Rendering:
- snack_r is registered with 1-cycle latency from pixel_xpos/pixel_ypos.
- snack_r = OR over i < snake_len of:
  (pixel_xpos >= x_i) && (pixel_xpos < x_i + BLOCK_W) && (pixel_ypos >= y_i) && (pixel_ypos < y_i + BLOCK_W).
- Segment coordinates are zero-extended to 11 bits before comparing.
- Rendering continues unchanged after fin.
- While a step updates storage, the render compare uses the pre-update values in that cycle.

Arithmetic:
- Coordinates are unsigned 10-bit; sums are computed at 11 bits.
- No wrap-around is ever stored; the wall checks prevent it.

Test Plan:
1. Reset, then pixel (400,300), then (385,305), then (370,300) -> snack_r = 1, 1, 0 one cycle later; snake_len = 3; fin = 0.
2. move_tick with dir_in = 11 -> head (410,300); segment 2 = (390,300); pixel (380,300) now gives snack_r = 0.
3. move_tick with dir_in = 10 (reverse) -> ignored; head (420,300). Then dir_in = 00 -> head (420,290).
4. grow, then move_tick three cycles later -> snake_len = 4, tail kept. grow and move_tick in the same cycle -> snake_len = 5. Sixteen more grow+tick pairs -> snake_len saturates at 16.
5. Steer up from y = 300 with 30 move_ticks -> head_y reaches 0. The next tick sets fin = 1 and head stays (x,0); a further tick leaves everything unchanged.
6. Grow to length 5, then steer down, left, up -> the up step hits segment 3, fin = 1. Assert sys_rst_n low mid-operation -> all reset values restored immediately, without waiting for a clock edge.
